// File: rtl/hdmi_island_scheduler_if.sv
`default_nettype none
// =============================================================================
// hdmi_island_scheduler_if : timing, request and period-control bundle
// Revision : 1.0
// =============================================================================
interface hdmi_island_scheduler_if;
    logic       i_enable;
    logic       i_hSync;
    logic       i_blank;
    logic [3:0] i_req;
    logic [3:0] o_grant;
    logic [1:0] o_sel;
    logic       o_pkt_start;
    logic       o_first;
    logic [1:0] o_period;
    logic       o_abort;

    modport slave (
        input  i_enable, i_hSync, i_blank, i_req,
        output o_grant, o_sel, o_pkt_start, o_first, o_period, o_abort
    );

    modport master (
        output i_enable, i_hSync, i_blank, i_req,
        input  o_grant, o_sel, o_pkt_start, o_first, o_period, o_abort
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_island_scheduler.sv
`default_nettype none
// =============================================================================
// hdmi_island_scheduler : sequences HDMI data islands in h-blank and arbitrates packet sources
// Revision : 1.0
// =============================================================================
module hdmi_island_scheduler #(
    parameter int START_DELAY  = 4,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int PKT_LEN      = 32,
    parameter int MAX_PKTS     = 2
) (
    input  wire logic              i_pixclk,
    input  wire logic              i_reset,
    hdmi_island_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        PRE    = 3'd2,
        LGUARD = 3'd3,
        PKT    = 3'd4,
        TGUARD = 3'd5
    } state_t;

    state_t     state;
    logic [5:0] count;
    logic [1:0] pkts;
    logic       rr_ptr;
    logic       prev_hsync;
    logic       prev_blank;
    logic       prev_enable;
    logic       armed;

    logic [3:0] grant;
    logic [1:0] sel;
    logic       pkt_start;
    logic       first;
    logic [1:0] period;
    logic       abort;

    logic       blank_rise;
    logic       blank_fall;
    logic       enable_fall;
    logic       qual;
    logic       any_req;
    logic       arb_valid;
    logic [1:0] arb_idx;
    logic [3:0] arb_grant;

    assign blank_rise  = bus.i_blank & ~prev_blank;
    assign blank_fall  = ~bus.i_blank & prev_blank;
    assign enable_fall = ~bus.i_enable & prev_enable;
    assign qual        = armed & bus.i_blank & (bus.i_hSync ^ prev_hsync);
    assign any_req     = |bus.i_req;

    // ACR and audio sample win outright; the two infoframes share a round-robin slot.
    always_comb begin
        arb_valid = 1'b1;
        arb_idx   = 2'd0;
        if (bus.i_req[0])                      arb_idx = 2'd0;
        else if (bus.i_req[1])                 arb_idx = 2'd1;
        else if (bus.i_req[2] && bus.i_req[3]) arb_idx = rr_ptr ? 2'd3 : 2'd2;
        else if (bus.i_req[2])                 arb_idx = 2'd2;
        else if (bus.i_req[3])                 arb_idx = 2'd3;
        else                                   arb_valid = 1'b0;
        arb_grant = arb_valid ? (4'b0001 << arb_idx) : 4'b0000;
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            count       <= 6'd0;
            pkts        <= 2'd0;
            rr_ptr      <= 1'b0;
            prev_hsync  <= 1'b0;
            prev_blank  <= 1'b0;
            prev_enable <= 1'b0;
            armed       <= 1'b0;
            grant       <= 4'd0;
            sel         <= 2'd0;
            pkt_start   <= 1'b0;
            first       <= 1'b0;
            period      <= 2'd0;
            abort       <= 1'b0;
        end else begin
            prev_hsync  <= bus.i_hSync;
            prev_blank  <= bus.i_blank;
            prev_enable <= bus.i_enable;
            grant       <= 4'd0;
            pkt_start   <= 1'b0;
            abort       <= 1'b0;

            if (blank_rise)
                armed <= 1'b1;
            else if (qual)
                armed <= 1'b0;

            if (state != IDLE && (blank_fall || enable_fall)) begin
                state  <= IDLE;
                count  <= 6'd0;
                pkts   <= 2'd0;
                sel    <= 2'd0;
                first  <= 1'b0;
                period <= 2'd0;
                abort  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (qual && bus.i_enable && any_req) begin
                            state <= DELAY;
                            count <= 6'(START_DELAY - 1);
                        end
                    end
                    DELAY: begin
                        if (count == 6'd0) begin
                            state  <= PRE;
                            period <= 2'd1;
                            count  <= 6'(PREAMBLE_LEN - 1);
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                    PRE: begin
                        if (count == 6'd0) begin
                            state  <= LGUARD;
                            period <= 2'd2;
                            count  <= 6'(GUARD_LEN - 1);
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                    LGUARD: begin
                        // With nothing pending a null packet still fills the slot.
                        if (count == 6'd0) begin
                            state     <= PKT;
                            period    <= 2'd3;
                            count     <= 6'(PKT_LEN - 1);
                            pkts      <= 2'd1;
                            first     <= 1'b1;
                            pkt_start <= 1'b1;
                            grant     <= arb_grant;
                            sel       <= arb_valid ? arb_idx : 2'd0;
                            if (arb_valid && arb_idx[1])
                                rr_ptr <= ~rr_ptr;
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                    PKT: begin
                        if (count == 6'd0) begin
                            if (pkts < 2'(MAX_PKTS) && any_req) begin
                                count     <= 6'(PKT_LEN - 1);
                                pkts      <= pkts + 2'd1;
                                first     <= 1'b0;
                                pkt_start <= 1'b1;
                                grant     <= arb_grant;
                                sel       <= arb_idx;
                                if (arb_idx[1])
                                    rr_ptr <= ~rr_ptr;
                            end else begin
                                state  <= TGUARD;
                                period <= 2'd2;
                                count  <= 6'(GUARD_LEN - 1);
                                sel    <= 2'd0;
                                first  <= 1'b0;
                            end
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                    TGUARD: begin
                        if (count == 6'd0) begin
                            state  <= IDLE;
                            period <= 2'd0;
                            pkts   <= 2'd0;
                        end else begin
                            count <= count - 6'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        period <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.o_grant     = grant;
    assign bus.o_sel       = sel;
    assign bus.o_pkt_start = pkt_start;
    assign bus.o_first     = first;
    assign bus.o_period    = period;
    assign bus.o_abort     = abort;
endmodule
`default_nettype wire

// File: tb/tb_hdmi_island_scheduler.sv
`default_nettype none
// =============================================================================
// tb_hdmi_island_scheduler : directed bench for the data-island scheduler
// Revision : 1.0
// =============================================================================
module tb_hdmi_island_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   auto_clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hdmi_island_scheduler_if bus ();

    hdmi_island_scheduler dut (
        .i_pixclk (clk),
        .i_reset  (rst),
        .bus      (bus)
    );

    task automatic check(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // A granted source withdraws its request on the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_clr)
            bus.i_req = bus.i_req & ~bus.o_grant;
    endtask

    function automatic logic [31:0] ctl_now();
        return {23'd0, bus.o_grant, bus.o_sel, bus.o_first, bus.o_pkt_start, bus.o_abort};
    endfunction

    // Cycle c counts clock edges after the hSync toggle; edge 1 is the qualifying edge.
    task automatic run_line(input bit active, input int npk,
                            input logic [3:0] g1, input logic [3:0] g2,
                            input logic [1:0] s1, input logic [1:0] s2,
                            input int drop_at, input int abort_at);
        int pend;
        bit ab;
        logic [1:0] ep, es;
        logic [3:0] eg;
        logic ef, eps, eab;
        pend = 15 + 32 * npk;
        bus.i_blank = 1'b1;
        repeat (10) tick();
        bus.i_hSync = ~bus.i_hSync;
        for (int c = 1; c <= 90; c++) begin
            tick();
            ab  = (abort_at > 0) && (c > abort_at);
            if (!active || ab)    ep = 2'd0;
            else if (c < 5)       ep = 2'd0;
            else if (c < 13)      ep = 2'd1;
            else if (c < 15)      ep = 2'd2;
            else if (c < pend)    ep = 2'd3;
            else if (c < pend + 2) ep = 2'd2;
            else                  ep = 2'd0;
            eg  = 4'd0;
            eps = 1'b0;
            es  = 2'd0;
            if (active && !ab) begin
                if (c == 15) begin eg = g1; eps = 1'b1; end
                if (npk == 2 && c == 47) begin eg = g2; eps = 1'b1; end
                if (c >= 15 && c < 47) es = s1;
                if (npk == 2 && c >= 47 && c < 79) es = s2;
            end
            ef  = active && !ab && c >= 15 && c < 47;
            eab = (abort_at > 0) && (c == abort_at + 1);
            check("period", c, {30'd0, bus.o_period}, {30'd0, ep});
            check("ctl", c, ctl_now(), {23'd0, eg, es, ef, eps, eab});
            if (c == drop_at)  bus.i_req = 4'd0;
            if (c == abort_at) bus.i_blank = 1'b0;
        end
        // A second hSync edge in the same blanking must not start another island.
        bus.i_hSync = ~bus.i_hSync;
        for (int c = 91; c <= 110; c++) begin
            tick();
            check("one_per_line", c, {30'd0, bus.o_period}, 32'd0);
        end
        bus.i_blank = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        bus.i_enable = 1'b1;
        bus.i_hSync  = 1'b0;
        bus.i_blank  = 1'b0;
        bus.i_req    = 4'd0;
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_period", 0, {30'd0, bus.o_period}, 32'd0);
        check("rst_ctl", 0, ctl_now(), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Basic island: ACR then audio sample.
        bus.i_req = 4'b0011;
        run_line(1'b1, 2, 4'b0001, 4'b0010, 2'd0, 2'd1, 0, 0);

        // Infoframe round-robin over three lines.
        auto_clr = 1'b0;
        bus.i_req = 4'b1100;
        for (int l = 0; l < 3; l++)
            run_line(1'b1, 2, 4'b0100, 4'b1000, 2'd2, 2'd3, 0, 0);
        auto_clr = 1'b1;

        // No request at the qualifying edge.
        bus.i_req = 4'd0;
        run_line(1'b0, 0, 4'd0, 4'd0, 2'd0, 2'd0, 0, 0);

        // Request withdrawn during DELAY gives a single null packet.
        bus.i_req = 4'b0010;
        run_line(1'b1, 1, 4'd0, 4'd0, 2'd0, 2'd0, 2, 0);

        // Blank falls during the 10th packet cycle.
        bus.i_req = 4'b0011;
        run_line(1'b1, 2, 4'b0001, 4'b0010, 2'd0, 2'd1, 0, 24);

        // Asynchronous reset in the preamble.
        bus.i_req   = 4'b0011;
        bus.i_blank = 1'b1;
        repeat (10) tick();
        bus.i_hSync = ~bus.i_hSync;
        repeat (7) tick();
        check("pre_before_rst", 7, {30'd0, bus.o_period}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_period", 7, {30'd0, bus.o_period}, 32'd0);
        check("async_rst_ctl", 7, ctl_now(), 32'd0);
        #2;
        rst = 1'b0;
        bus.i_blank = 1'b0;
        bus.i_req   = 4'd0;
        repeat (3) tick();
        bus.i_req = 4'b0011;
        run_line(1'b1, 2, 4'b0001, 4'b0010, 2'd0, 2'd1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hdmi_island_scheduler.md
Name: hdmi_island_scheduler

Overview:
- Sequences HDMI data-island periods during horizontal blanking.
- Arbitrates up to four packet sources for the available packet slots: ACR, audio sample, AVI infoframe, audio infoframe.
- Drives the period/control signals that tell the packet encoder and the TMDS mux when to emit preamble, guard band and packet bits.
- Sits between the video timing generator and the data-island encoder, in the i_pixclk domain.

Parameters:
- START_DELAY, 4: cycles from the qualifying hSync edge to the first preamble cycle.
- PREAMBLE_LEN, 8: data-island preamble length in cycles.
- GUARD_LEN, 2: leading and trailing guard-band length in cycles.
- PKT_LEN, 32: cycles per packet.
- MAX_PKTS, 2: maximum packets per island (1..3).

Ports:
- i_pixclk  in  1  pixel clock
- i_reset  in  1  asynchronous active-high reset
- i_enable  in  1  island generation enable (audio enable)
- i_hSync  in  1  horizontal sync, either polarity
- i_blank  in  1  blanking active
- i_req  in  4  packet requests: [0] ACR, [1] audio sample, [2] AVI IF, [3] audio IF
- o_grant  out  4  one-hot, one-cycle grant pulse
- o_sel  out  2  index of the source currently being sent
- o_pkt_start  out  1  pulse on the first cycle of each packet
- o_first  out  1  high during the first packet of an island
- o_period  out  2  0 control, 1 preamble, 2 guard, 3 packet data
- o_abort  out  1  one-cycle pulse when an island is cut short

Behaviour:
- Clock and reset: single clock i_pixclk. Reset is asynchronous, active-high, named i_reset.
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer selects [2].
- Registers: all outputs are registered. o_period, o_sel and o_first change on the same edge.
- Slot qualification:
  - Track prevHSync and prevBlank.
  - A rising edge of i_blank arms the slot.
  - The first hSync transition (either direction) while armed and i_blank=1 is the qualifying edge; it disarms.
  - One island per line at most.
- FSM states:
  - IDLE: on qualifying edge with i_enable=1 and |i_req → DELAY, loading count = START_DELAY-1. If no request, stay in IDLE (no island).
  - DELAY: counts down; at 0 → PRE.
  - PRE: o_period=1 for PREAMBLE_LEN cycles → LGUARD.
  - LGUARD: o_period=2 for GUARD_LEN cycles → PKT.
  - PKT: o_period=3 for PKT_LEN cycles. At the end, if packets sent < MAX_PKTS and |i_req → PKT again (back-to-back, no guard between packets); otherwise → TGUARD.
  - TGUARD: o_period=2 for GUARD_LEN cycles → IDLE.
- Arbitration: evaluated on the cycle before each PKT entry. Fixed priority [0] > [1]; then round-robin between [2] and [3], where the pointer toggles after each IF grant.
- Grant timing:
  - o_grant, o_pkt_start and the updated o_sel are asserted on the first PKT cycle.
  - A source must deassert req by the next cycle unless it has another packet.
  - A req asserted during a PKT cycle is considered only for the next slot decision.
- Empty arbitration: if no req is present at LGUARD end, emit one null packet (o_sel=0, no grant, o_first=1) so that guard and packet structure is preserved.
- o_first: 1 for the whole first PKT of an island, 0 for later packets.
- Aborts:
  - i_blank falling, or i_enable falling, in any non-IDLE state → IDLE next cycle, o_period=0, o_abort pulse.
  - Any grant already issued stands. No further grants follow.
- Reset mid-island: immediate IDLE, all outputs 0.
- Counters: 6-bit down counters, no wrap. Packet count is 2-bit and saturates at MAX_PKTS.

Test Plan:
- Basic island: blank rises; hSync toggles 10 cycles later; i_req=4'b0011 held.
  - Expected: o_period=1 from 4 cycles after the edge for 8 cycles, then 2×2, then 3×64, then 2×2.
  - Grants 4'b0001 at the first PKT cycle, 4'b0010 32 cycles later.
  - o_first high only for the first 32 PKT cycles.
- Round-robin: i_req=4'b1100 constant, MAX_PKTS=2, 3 lines.
  - Expected: grants [2],[3] on line 1, then [2],[3] on each following line.
  - Exactly 2 packets per island.
- No request: i_req=0 at the qualifying edge → o_period stays 0 for the whole line, no grant.
- Null packet: req [1] drops during DELAY → one PKT with o_sel=0, no grant, then TGUARD.
- Abort: i_blank falls during the 10th PKT cycle → o_period=0 next cycle, o_abort=1 for 1 cycle, no second grant.
- Async reset: pulse i_reset in PRE → outputs 0 immediately; the next line's island proceeds normally.
